// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//
// Contents:
//   STATE_W      - width of the AES state / block (128)
//   byte_t       - one state byte
//   col_t        - one state column (4 bytes, row 0 in the MSBs)
//   dec_fsm_e    - control states of the inverse round engine
//   nr_is_legal  - true for the round counts AES defines (10, 12, 14)
//   xtime        - multiply by x (0x02) in GF(2^8) mod x^8+x^4+x^3+x+1
package aes_pkg;

    localparam int unsigned STATE_W = 128;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] col_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } dec_fsm_e;

    function automatic logic nr_is_legal(input int unsigned nr);
        return (nr == 10) || (nr == 12) || (nr == 14);
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: 256-entry combinational lookup.
//
// Ports:
//   in_byte  - substituted byte
//   out_byte - InvSubBytes(in_byte)
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES decryption engine: one inverse round per clock.
//
// A block is accepted in IDLE (initial AddRoundKey with key NR), then NR-1
// full inverse rounds run in ROUND, the last round (no InvMixColumns) runs in
// FINAL, and the plaintext is held in DONE until the consumer takes it.
// Round keys come from an external schedule: rk_idx selects, rk returns the
// key combinationally in the same cycle.
//
// Parameters:
//   NR        - cipher rounds: 10, 12 or 14
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   abort     - (AES_DEC_ABORT_EN only) drop the block in flight
//   in_valid  - ciphertext offered
//   in_ready  - engine idle and able to accept a block
//   ct        - ciphertext, byte 0 at [127:120], column-major
//   rk_idx    - index of the round key needed this cycle
//   rk        - round key rk_idx
//   out_valid - plaintext valid
//   out_ready - plaintext consumer ready
//   pt        - plaintext, same byte order as ct
//
// Optional feature macro: AES_DEC_ABORT_EN adds the abort input.
module aes_inv_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef AES_DEC_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] ct,
    output logic [3:0]         rk_idx,
    input  logic [STATE_W-1:0] rk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] pt
);

    if (!nr_is_legal(NR)) begin : g_bad_nr
        $error("aes_inv_round_engine: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] R_INIT = 4'(NR - 1);

    // ------------------------------------------------------------------
    // Combinational round helpers
    // ------------------------------------------------------------------

    // Byte (row r, col c) lives at byte index 4*c + r, MSB first.
    function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    // Multiply by a constant below 16 using the xtime chain.
    function automatic byte_t gf_mul_k(input byte_t b, input logic [3:0] k);
        byte_t p;
        byte_t x;
        p = '0;
        x = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic col_t inv_mix_column(input col_t c);
        byte_t a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul_k(a0, 4'he) ^ gf_mul_k(a1, 4'hb) ^ gf_mul_k(a2, 4'hd) ^ gf_mul_k(a3, 4'h9),
                gf_mul_k(a0, 4'h9) ^ gf_mul_k(a1, 4'he) ^ gf_mul_k(a2, 4'hb) ^ gf_mul_k(a3, 4'hd),
                gf_mul_k(a0, 4'hd) ^ gf_mul_k(a1, 4'h9) ^ gf_mul_k(a2, 4'he) ^ gf_mul_k(a3, 4'hb),
                gf_mul_k(a0, 4'hb) ^ gf_mul_k(a1, 4'hd) ^ gf_mul_k(a2, 4'h9) ^ gf_mul_k(a3, 4'he)};
    endfunction

    function automatic logic [STATE_W-1:0] inv_mix_columns(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers and datapath
    // ------------------------------------------------------------------

    dec_fsm_e           fsm_q, fsm_d;
    logic [3:0]         r_q, r_d;
    logic [STATE_W-1:0] state_q, state_d;

    logic [STATE_W-1:0] sr;
    logic [STATE_W-1:0] sb;
    logic [STATE_W-1:0] ark;
    logic               abort_w;

`ifdef AES_DEC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign sr = inv_shift_rows(state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (sr[127 - 8 * i -: 8]),
            .out_byte (sb[127 - 8 * i -: 8])
        );
    end

    assign ark = sb ^ rk;
    assign pt  = state_q;

    always_comb begin
        fsm_d     = fsm_q;
        r_d       = r_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = NR_IDX;

        unique case (fsm_q)
            IDLE: begin
                in_ready = !abort_w;
                // ct and rk are only sampled on an accept, so X elsewhere cannot leak in.
                if (in_valid && !abort_w) begin
                    state_d = ct ^ rk;
                    r_d     = R_INIT;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = r_q;
                state_d = inv_mix_columns(ark);
                if (r_q == 4'd1) begin
                    fsm_d = FINAL;
                end else begin
                    r_d = r_q - 4'd1;
                end
            end
            FINAL: begin
                rk_idx  = 4'd0;
                state_d = ark;
                fsm_d   = DONE;
            end
            DONE: begin
                out_valid = !abort_w;
                if (out_ready) begin
                    fsm_d = IDLE;
                    r_d   = R_INIT;
                end
            end
            default: begin
                fsm_d = IDLE;
                r_d   = R_INIT;
            end
        endcase

        // Abort drops the block in flight; state holds so pt does not move.
        if (abort_w && (fsm_q != IDLE)) begin
            fsm_d   = IDLE;
            r_d     = R_INIT;
            state_d = state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            r_q     <= R_INIT;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            r_q     <= r_d;
            state_q <= state_d;
        end
    end

endmodule
